// File: rtl/march_op_sequencer_pkg.sv
// Shared PMBIST march definitions: element size, op/polarity codes
// and the per-address sequencer state encoding.
package march_op_sequencer_pkg;

  localparam int MARCH_MAX_OPS = 8;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  localparam logic POL_ZERO = 1'b0;
  localparam logic POL_ONE  = 1'b1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } seq_state_e;

endpackage

// File: rtl/march_op_sequencer_op_field_mux.sv
// op_field_mux: selects op/polarity k from packed element fields.
// in: op_vec, pol_vec, idx   out: op, pol (zero if idx out of range)
module op_field_mux #(
  parameter int MAX_OPS = 8,
  parameter int OP_W    = 1,
  parameter int POL_W   = 1,
  parameter int CNT_W   = $clog2(MAX_OPS)
) (
  input  logic [MAX_OPS*OP_W-1:0]  op_vec,
  input  logic [MAX_OPS*POL_W-1:0] pol_vec,
  input  logic [CNT_W-1:0]         idx,
  output logic [OP_W-1:0]          op,
  output logic [POL_W-1:0]         pol
);

  always_comb begin
    op  = '0;
    pol = '0;
    if (int'(idx) < MAX_OPS) begin
      op  = op_vec[int'(idx)*OP_W +: OP_W];
      pol = pol_vec[int'(idx)*POL_W +: POL_W];
    end
  end

endmodule

// File: rtl/march_op_sequencer.sv
// Per-address march op sequencer: steps ops 0..last_idx per address.
// in: start/abort, op_in/pol_in/no_in, addr_last, mem_rdy
// out: op_out/pol_out/op_valid/op_idx, last_op, addr_step(_q),
//      elem_done, busy
module march_op_sequencer
  import march_op_sequencer_pkg::*;
#(
  parameter int MAX_OPS = MARCH_MAX_OPS,
  parameter int OP_W    = 1,
  parameter int POL_W   = 1,
  parameter int CNT_W   = $clog2(MAX_OPS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic [MAX_OPS*OP_W-1:0]  op_in,
  input  logic [MAX_OPS*POL_W-1:0] pol_in,
  input  logic [CNT_W-1:0]         no_in,
  input  logic                     addr_last,
  input  logic                     mem_rdy,
  output logic [OP_W-1:0]          op_out,
  output logic [POL_W-1:0]         pol_out,
  output logic                     op_valid,
  output logic [CNT_W-1:0]         op_idx,
  output logic                     last_op,
  output logic                     addr_step,
  output logic                     addr_step_q,
  output logic                     elem_done,
  output logic                     busy
);

  localparam logic [CNT_W-1:0] IDX_MAX = CNT_W'(MAX_OPS - 1);

  seq_state_e               state_q, state_d;
  logic [CNT_W-1:0]         op_idx_q, op_idx_d;
  logic [CNT_W-1:0]         last_idx_q, last_idx_d;
  logic [MAX_OPS*OP_W-1:0]  op_sh_q, op_sh_d;
  logic [MAX_OPS*POL_W-1:0] pol_sh_q, pol_sh_d;
  logic                     addr_step_q_q, addr_step_q_d;
  logic                     elem_done_q, elem_done_d;

  assign op_valid    = (state_q == S_RUN);
  assign busy        = (state_q != S_IDLE);
  assign op_idx      = op_idx_q;
  assign last_op     = op_valid && (op_idx_q == last_idx_q);
  assign addr_step   = last_op && mem_rdy;
  assign addr_step_q = addr_step_q_q;
  assign elem_done   = elem_done_q;

  op_field_mux #(
    .MAX_OPS (MAX_OPS),
    .OP_W    (OP_W),
    .POL_W   (POL_W),
    .CNT_W   (CNT_W)
  ) u_mux (
    .op_vec  (op_sh_q),
    .pol_vec (pol_sh_q),
    .idx     (op_idx_q),
    .op      (op_out),
    .pol     (pol_out)
  );

  always_comb begin
    state_d       = state_q;
    op_idx_d      = op_idx_q;
    last_idx_d    = last_idx_q;
    op_sh_d       = op_sh_q;
    pol_sh_d      = pol_sh_q;
    addr_step_q_d = addr_step;
    elem_done_d   = 1'b0;

    if (abort) begin
      // abort beats start and mem_rdy; in IDLE it just blocks start
      state_d  = S_IDLE;
      op_idx_d = '0;
    end else if (start) begin
      state_d    = S_RUN;
      op_idx_d   = '0;
      op_sh_d    = op_in;
      pol_sh_d   = pol_in;
      last_idx_d = (no_in > IDX_MAX) ? IDX_MAX : no_in;
    end else if (state_q == S_RUN && mem_rdy) begin
      if (last_op) begin
        op_idx_d = '0;
        if (addr_last) begin
          state_d     = S_IDLE;
          elem_done_d = 1'b1;
        end
      end else begin
        op_idx_d = op_idx_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      op_idx_q      <= '0;
      last_idx_q    <= '0;
      op_sh_q       <= '0;
      pol_sh_q      <= '0;
      addr_step_q_q <= 1'b0;
      elem_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_idx_q      <= op_idx_d;
      last_idx_q    <= last_idx_d;
      op_sh_q       <= op_sh_d;
      pol_sh_q      <= pol_sh_d;
      addr_step_q_q <= addr_step_q_d;
      elem_done_q   <= elem_done_d;
    end
  end

endmodule

// File: tb/tb_march_op_sequencer.sv
// Directed bench for march_op_sequencer (8-op and 6-op instances).
// Per-cycle expectations go through a scoreboard queue.
module tb_march_op_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 8-op instance
  logic       rst, start, abort, addr_last, mem_rdy;
  logic [7:0] op_in, pol_in;
  logic [2:0] no_in;
  logic       op_out, pol_out, op_valid, last_op;
  logic       addr_step, addr_step_q, elem_done, busy;
  logic [2:0] op_idx;

  march_op_sequencer #(.MAX_OPS(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .op_in(op_in), .pol_in(pol_in), .no_in(no_in),
    .addr_last(addr_last), .mem_rdy(mem_rdy),
    .op_out(op_out), .pol_out(pol_out), .op_valid(op_valid),
    .op_idx(op_idx), .last_op(last_op), .addr_step(addr_step),
    .addr_step_q(addr_step_q), .elem_done(elem_done), .busy(busy)
  );

  // 6-op instance for the clamp case
  logic       b_start, b_abort, b_addr_last, b_mem_rdy;
  logic [5:0] b_op_in, b_pol_in;
  logic [2:0] b_no_in;
  logic       b_op_out, b_pol_out, b_op_valid, b_last_op;
  logic       b_addr_step, b_addr_step_q, b_elem_done, b_busy;
  logic [2:0] b_op_idx;

  march_op_sequencer #(.MAX_OPS(6)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .abort(b_abort),
    .op_in(b_op_in), .pol_in(b_pol_in), .no_in(b_no_in),
    .addr_last(b_addr_last), .mem_rdy(b_mem_rdy),
    .op_out(b_op_out), .pol_out(b_pol_out),
    .op_valid(b_op_valid), .op_idx(b_op_idx),
    .last_op(b_last_op), .addr_step(b_addr_step),
    .addr_step_q(b_addr_step_q), .elem_done(b_elem_done),
    .busy(b_busy)
  );

  typedef struct packed {
    logic [2:0] idx;
    logic       op;
    logic       pol;
    logic       valid;
    logic       last;
    logic       step;
    logic       stepq;
    logic       done;
    logic       busy;
  } exp_t;

  exp_t sb[$];

  function automatic exp_t mk(int idx, int op, int pol, int v,
                              int l, int s, int sq, int d, int b);
    exp_t e;
    e.idx   = 3'(idx);
    e.op    = 1'(op);
    e.pol   = 1'(pol);
    e.valid = 1'(v);
    e.last  = 1'(l);
    e.step  = 1'(s);
    e.stepq = 1'(sq);
    e.done  = 1'(d);
    e.busy  = 1'(b);
    return e;
  endfunction

  task automatic chk(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0d exp %0d", tag, obs, exp);
    end
  endtask

  // Inputs are set at the negedge before calling; outputs are
  // sampled 1ns later and compared against the queued entry.
  task automatic cyc(string tag, exp_t e);
    exp_t x;
    sb.push_back(e);
    #1;
    x = sb.pop_front();
    chk({tag, ".idx"},   int'(op_idx),      int'(x.idx));
    chk({tag, ".op"},    int'(op_out),      int'(x.op));
    chk({tag, ".pol"},   int'(pol_out),     int'(x.pol));
    chk({tag, ".valid"}, int'(op_valid),    int'(x.valid));
    chk({tag, ".last"},  int'(last_op),     int'(x.last));
    chk({tag, ".step"},  int'(addr_step),   int'(x.step));
    chk({tag, ".stepq"}, int'(addr_step_q), int'(x.stepq));
    chk({tag, ".done"},  int'(elem_done),   int'(x.done));
    chk({tag, ".busy"},  int'(busy),        int'(x.busy));
    @(negedge clk);
  endtask

  // ops {R,W,R}, pols {0,1,1}
  localparam logic [2:0] OPS  = 3'b010;
  localparam logic [2:0] POLS = 3'b110;

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    addr_last = 1'b0; mem_rdy = 1'b0;
    op_in = '0; pol_in = '0; no_in = '0;
    b_start = 1'b0; b_abort = 1'b0; b_addr_last = 1'b0;
    b_mem_rdy = 1'b0; b_op_in = '0; b_pol_in = '0; b_no_in = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    cyc("reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

    // basic march: 3 ops x 3 addresses
    op_in = {5'b0, OPS}; pol_in = {5'b0, POLS}; no_in = 3'd2;
    start = 1'b1; mem_rdy = 1'b1;
    cyc("start", mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    start = 1'b0;
    for (int a = 0; a < 3; a++) begin
      for (int k = 0; k < 3; k++) begin
        logic [2:0] o, p;
        o = OPS; p = POLS;
        addr_last = (a == 2);
        cyc("march", mk(k, o[k], p[k], 1, k == 2, k == 2,
                        (k == 0 && a > 0), 0, 1));
      end
    end
    addr_last = 1'b0;
    cyc("done", mk(0, 0, 0, 0, 0, 0, 1, 1, 0));
    cyc("idle", mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

    // stall at idx 1, with IR change mid-element
    start = 1'b1;
    cyc("st2", mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    start = 1'b0;
    cyc("run0", mk(0, 0, 0, 1, 0, 0, 0, 0, 1));
    mem_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        op_in = ~op_in; pol_in = ~pol_in;
      end
      cyc("stall", mk(1, 1, 1, 1, 0, 0, 0, 0, 1));
    end
    mem_rdy = 1'b1;
    cyc("run1", mk(1, 1, 1, 1, 0, 0, 0, 0, 1));

    // restart at idx 2 loads the changed fields (op0=1, pol0=1)
    mem_rdy = 1'b0; start = 1'b1;
    cyc("rst_at2", mk(2, 0, 1, 1, 1, 0, 0, 0, 1));
    start = 1'b0;
    cyc("reload", mk(0, 1, 1, 1, 0, 0, 0, 0, 1));

    // start+abort in RUN: abort wins
    mem_rdy = 1'b1; start = 1'b1; abort = 1'b1;
    cyc("sa_run", mk(0, 1, 1, 1, 0, 0, 0, 0, 1));
    cyc("sa_idle", mk(0, 1, 1, 0, 0, 0, 0, 0, 0));
    start = 1'b0; abort = 1'b0;
    cyc("sa_hold", mk(0, 1, 1, 0, 0, 0, 0, 0, 0));

    // single-op element: last_op always 1, addr_step = mem_rdy
    op_in = 8'h01; pol_in = 8'h00; no_in = 3'd0;
    start = 1'b1; mem_rdy = 1'b1; addr_last = 1'b0;
    cyc("s1_start", mk(0, 1, 1, 0, 0, 0, 0, 0, 0));
    start = 1'b0;
    cyc("s1_a", mk(0, 1, 0, 1, 1, 1, 0, 0, 1));
    mem_rdy = 1'b0;
    cyc("s1_b", mk(0, 1, 0, 1, 1, 0, 1, 0, 1));
    mem_rdy = 1'b1;
    cyc("s1_c", mk(0, 1, 0, 1, 1, 1, 0, 0, 1));
    mem_rdy = 1'b0; abort = 1'b1;
    cyc("s1_abort", mk(0, 1, 0, 1, 1, 0, 1, 0, 1));
    abort = 1'b0;
    cyc("s1_idle", mk(0, 1, 0, 0, 0, 0, 0, 0, 0));

    // reset mid-element at idx 3
    op_in = 8'hAA; pol_in = 8'h55; no_in = 3'd5;
    start = 1'b1; mem_rdy = 1'b1;
    cyc("r_start", mk(0, 1, 0, 0, 0, 0, 0, 0, 0));
    start = 1'b0;
    for (int k = 0; k < 3; k++)
      cyc("r_run", mk(k, k % 2, (k + 1) % 2, 1, 0, 0, 0, 0, 1));
    rst = 1'b1;
    cyc("r_at3", mk(3, 1, 0, 1, 0, 0, 0, 0, 1));
    rst = 1'b0; mem_rdy = 1'b0;
    cyc("r_after", mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("r_after2", mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

    // clamp on the 6-op instance: no_in=7 -> last_idx=5
    b_op_in = 6'b101010; b_pol_in = 6'b000001; b_no_in = 3'd7;
    b_start = 1'b1; b_mem_rdy = 1'b1; b_addr_last = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("b.idx",  int'(b_op_idx),    k);
      chk("b.op",   int'(b_op_out),    k % 2);
      chk("b.last", int'(b_last_op),   int'(k == 5));
      chk("b.step", int'(b_addr_step), int'(k == 5));
      @(negedge clk);
    end
    #1;
    chk("b.done", int'(b_elem_done), 1);
    chk("b.busy", int'(b_busy), 0);
    chk("b.idx0", int'(b_op_idx), 0);
    @(negedge clk);

    chk("sb.empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/march_op_sequencer.md
# march_op_sequencer

Parametrised per-address operation sequencer for the PMBIST march engine, and successor to the fixed-width cycle controller. It latches the decoded op, polarity and op-count fields of a march element on `start`, then steps through ops 0..`last_idx` once per address. Stepping is gated by a memory-ready handshake. It emits the current op/polarity, a last-op flag, an address-step strobe and an element-done pulse. It sits between the instruction decoder and the address generator / memory interface.

## Interface
- `MAX_OPS`, 8: maximum ops per march element (≥2).
- `OP_W`, 1: width of one op code.
- `POL_W`, 1: width of one polarity field.
- `CNT_W`, $clog2(MAX_OPS): op-index width (derived; do not override).

- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: load element fields and begin at op 0.
- `abort` in 1: terminate the element and return to IDLE.
- `op_in` in MAX_OPS*OP_W: packed ops; op k is at bits [k*OP_W +: OP_W].
- `pol_in` in MAX_OPS*POL_W: packed polarities, same packing as `op_in`.
- `no_in` in CNT_W: index of last op (op count − 1).
- `addr_last` in 1: address generator is at the final address of the element.
- `mem_rdy` in 1: memory accepts the current op this cycle.
- `op_out` out OP_W: current op.
- `pol_out` out POL_W: current polarity.
- `op_valid` out 1: `op_out`/`pol_out` valid; high in RUN.
- `op_idx` out CNT_W: current op index.
- `last_op` out 1: combinational; `op_valid && op_idx == last_idx`.
- `addr_step` out 1: combinational; `last_op && mem_rdy` (address generator advances).
- `addr_step_q` out 1: `addr_step` registered one cycle (legacy compare-flop equivalent).
- `elem_done` out 1: one-cycle registered pulse at the end of the element.
- `busy` out 1: state != IDLE.

## Operation
- States are IDLE and RUN.
- **IDLE → RUN** on `start`:
  - Shadow registers capture `op_in`, `pol_in` and `last_idx = min(no_in, MAX_OPS−1)`.
  - `op_idx` is set to 0.
- **RUN, `mem_rdy`=0**: all state holds, outputs stable (stall).
- **RUN, `mem_rdy`=1, not last op**: `op_idx` increments by 1.
- **RUN, `mem_rdy`=1, last op, `addr_last`=0**: `op_idx` wraps to 0; the element repeats at the next address.
- **RUN, `mem_rdy`=1, last op, `addr_last`=1**: → IDLE. `elem_done`=1 next cycle and `op_idx` cleared.
- `last_idx`=0 (single-op element): `last_op` is high on every RUN cycle; `addr_step` = `mem_rdy`.
- **`abort` in RUN**: → IDLE next cycle, `op_idx`=0, no `elem_done`. `abort` overrides `mem_rdy`.
- **`start` in RUN**: reload shadows, `op_idx`=0, stay in RUN, no `elem_done`. `start` has priority over stepping. When `start` and `abort` coincide, `abort` wins.
- `start` in IDLE with `abort`=1 is ignored.
- Shadow registers change only on accepted `start`. IR field changes mid-element have no effect.
- `op_out`/`pol_out` are driven from the shadow registers indexed by `op_idx`. In IDLE they show index 0 of the shadows, and `op_valid`=0.
- `addr_last` is sampled only at the last-op accept.

## Timing
- **Reset values**: state=IDLE, `op_idx`=0, shadows=0, `op_valid`=0, `last_op`=0, `addr_step`=0, `addr_step_q`=0, `elem_done`=0, `busy`=0. `op_out`=0, `pol_out`=0.
- `rst` mid-RUN discards the element; there is no `elem_done`.
- **Latency**: `start` sampled at edge N; first op is valid in cycle N+1.
- Each op is held until the cycle in which `mem_rdy`=1. Throughput is one op/cycle with no stalls.
- `addr_step` is combinational in the accept cycle. `addr_step_q` and `elem_done` assert the following cycle.
- Back-to-back elements: `start` asserted in the same cycle as `elem_done` yields RUN in the next cycle. There is a one-cycle IDLE gap minimum.

## Structure
- Place these in the shared PMBIST defines/package: `MARCH_MAX_OPS`, the op encodings (read/write) and the polarity encoding.
- Sub-module `op_field_mux`: parametrised combinational selector (MAX_OPS, OP_W, POL_W) from packed op/pol by index. It replaces the fixed-width control mux.
- Counter, FSM and shadow registers live in the top module.

## Test plan
- **Basic march**: MAX_OPS=8, `no_in`=2, ops {R,W,R}, `mem_rdy`=1, `addr_last` high on the 3rd address.
  - `op_idx` runs 0,1,2 three times.
  - `addr_step` fires 3×.
  - `elem_done` pulses once, 1 cycle after the 9th op.
- **Stall**: `mem_rdy` low for 4 cycles at `op_idx`=1 → `op_idx`, `op_out` and `pol_out` are frozen. `addr_step` stays 0.
- **Clamp and single-op**:
  - `no_in`=7 with MAX_OPS=6 → `last_idx`=5.
  - `no_in`=0 → `last_op` is constant 1, `addr_step`=`mem_rdy`.
- **Priority**: `start` in RUN at `op_idx`=2 → `op_idx`=0 with new shadows. `start`+`abort` together → IDLE, `busy`=0.
- **Reset mid-element**: `rst` at `op_idx`=3 → all outputs at reset values the next cycle, no `elem_done`.
- **IR isolation**: change `op_in`/`pol_in` during RUN → `op_out`/`pol_out` are unchanged until the next `start`.
